prio_case_arbiter: RTL and testbench
====================================

# prio_case_arbiter

- Parametrised N-channel arbiter and data multiplexer; the sequential successor to the team's priority/unique case-selection muxes.
- Each cycle it selects one requesting channel:
  - fixed priority: lowest index wins, first-match semantics;
  - round-robin: rotating priority.
- The selected W-bit word goes to a registered valid/ready output stage.
- When nothing is selected, the last data word is held rather than forced to X.
- Multi-request collisions are counted, making unique-case violations observable in hardware.
- Sits between several producers and one downstream consumer.

## Interface
- N, 4: number of request channels, 2..16.
- W, 8: data width per channel.
- MODE, 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- CNT_W, 8: width of the collision counter.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  per-channel request; bit i belongs to channel i.
- data  in  N*W  channel i data in bits [i*W +: W].
- req_ack  out  N  one-hot, combinational; channel i is accepted in this cycle.
- out_valid  out  1  registered output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  W  registered selected data; holds its last value when no new word is loaded.
- out_ch  out  clog2(N) (min 1)  index of the channel that produced out_data.
- collision_cnt  out  CNT_W  saturating count of accepted grants made while more than one req bit was set.

## Operation
- load = !out_valid || out_ready.
- Grant selection (combinational, from the current req):
  - MODE 0: g = lowest i with req[i]=1.
  - MODE 1: g = first i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around).
- Acceptance:
  - When load=1 and |req=1: req_ack[g]=1 and all other req_ack bits are 0.
  - Otherwise req_ack=0.
  - A producer treats req[i] & req_ack[i] at a rising edge as a completed transfer.
- Register update on an acceptance cycle:
  - out_data <= data[g], out_ch <= g, out_valid <= 1.
  - MODE 1 only: ptr <= (g==N-1) ? 0 : g+1.
- load=1 with req=0:
  - out_valid <= 0.
  - out_data, out_ch and ptr hold (no X, no clear).
- load=0 (out_valid=1, out_ready=0):
  - All output registers and ptr hold.
  - req_ack=0; requests stay pending.
- Collision counting:
  - On an acceptance cycle where popcount(req) >= 2, collision_cnt increments.
  - It saturates at 2^CNT_W-1 and never wraps.
- ptr never moves without an acceptance.
- MODE 0 has no ptr state; an implementation may tie it to 0.

## Timing
- Reset state: out_valid=0, out_data=0, out_ch=0, collision_cnt=0, ptr=0.
- req_ack during reset: 0 (follows the logic, since out_valid=0 makes load=1; it is gated by rst).
- Latency: req sampled in cycle t → out_valid/out_data updated at edge t+1; one register stage.
- Throughput: one word per cycle while out_ready=1 and requests are present.
- Backpressure: the output stage is a single register. With out_ready=0 and out_valid=1, no new acceptance takes place.
- Simultaneous out_ready=1 and a new request: the old word drains and the new word loads at the same edge (no bubble).
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); an in-flight word is discarded.
- Reset release: deassertion is synchronised externally; the first acceptance can occur in the first cycle after release.
- N=2: ptr toggles between 0 and 1. clog2 widths are at least 1.

## Test plan
- MODE0, N=4, W=8:
  - req=4'b1010, data ch1=0x11, ch3=0x33, out_ready=1 → req_ack=4'b0010; next cycle out_data=0x11, out_ch=1, collision_cnt=1.
- MODE1, N=4, req=4'b1111 held, out_ready=1 for 8 cycles:
  - grant order 0,1,2,3,0,1,2,3; collision_cnt=8.
  - Same with req=4'b1001: order 0,3,0,3.
- Backpressure, MODE1:
  - Load 0xA5 from ch2, then hold out_ready=0 for 5 cycles with req=4'b0001 → out_data stays 0xA5, req_ack=0, ptr stays 3.
  - On out_ready=1, ch0 is granted that cycle and out_data=data[0] at the next edge.
- Hold on no match:
  - After 0x5A is delivered, set req=0, out_ready=1 → out_valid=0 next cycle; out_data stays 0x5A, out_ch unchanged.
- Saturation, CNT_W=2:
  - 5 collision grants → collision_cnt reads 1,2,3,3,3.
- Async reset:
  - Pulse rst mid-clock while out_valid=1 and collision_cnt=2 → out_valid, out_data, collision_cnt read 0 before the next edge.
  - After release, MODE1 grants start from ch0.

Source files
------------

// File: rtl/prio_case_arbiter_if.sv
// Producer/consumer bus of the N-channel arbiter: request side, output stage and collision counter.
interface prio_case_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned CH_W = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic [N-1:0]     req_ack;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CH_W-1:0]  out_ch;
    logic [CNT_W-1:0] collision_cnt;

    // Producers and consumer side
    modport master (
        output req, data, out_ready,
        input  req_ack, out_valid, out_data, out_ch, collision_cnt
    );

    // Arbiter side
    modport slave (
        input  req, data, out_ready,
        output req_ack, out_valid, out_data, out_ch, collision_cnt
    );
endinterface

// File: rtl/prio_case_arbiter.sv
// N-channel arbiter + data mux with a single registered valid/ready output stage.
// MODE 0: fixed priority (index 0 highest). MODE 1: round-robin from ptr.
// Counts grants made while several requests collided (saturating).
module prio_case_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    prio_case_arbiter_if.slave bus
);
    localparam int unsigned CH_W = ($clog2(N) < 1) ? 1 : $clog2(N);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [CH_W-1:0]  out_ch_q,    out_ch_d;
    logic [CH_W-1:0]  ptr_q,       ptr_d;
    logic [CNT_W-1:0] coll_cnt_q,  coll_cnt_d;

    logic             grant_vld_c;
    logic [CH_W-1:0]  grant_idx_c;
    logic             multi_req_c;
    logic             load_c;
    logic             accept_c;
    logic [W-1:0]     grant_data_c;

    // Grant search: lowest index, or first match rotating from ptr
    always_comb begin
        int j;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        j           = 0;
        if (MODE == 0) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (bus.req[i]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = CH_W'(i);
                end
            end
        end else begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                j = int'(ptr_q) + k;
                if (j >= int'(N)) j = j - int'(N);
                if (bus.req[CH_W'(j)]) begin
                    grant_vld_c = 1'b1;
                    grant_idx_c = CH_W'(j);
                end
            end
        end
    end

    // Collision detect (two or more requests) and granted data mux
    always_comb begin
        int unsigned ones;
        ones         = 0;
        grant_data_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (bus.req[i]) ones = ones + 1;
            if (grant_idx_c == CH_W'(i)) grant_data_c = bus.data[i*int'(W) +: W];
        end
        multi_req_c = (ones >= 2);
    end

    // Acceptance handshake; req_ack is combinational and suppressed during reset
    always_comb begin
        load_c      = !out_valid_q || bus.out_ready;
        accept_c    = load_c && grant_vld_c;
        bus.req_ack = '0;
        if (accept_c && !rst) bus.req_ack[grant_idx_c] = 1'b1;
    end

    // Next state of the output stage, pointer and collision counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        coll_cnt_d  = coll_cnt_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data_c;
            out_ch_d    = grant_idx_c;
            if (MODE == 1) begin
                ptr_d = (grant_idx_c == CH_W'(N - 1)) ? '0 : CH_W'(grant_idx_c + 1'b1);
            end
            if (multi_req_c && (coll_cnt_q != {CNT_W{1'b1}})) begin
                coll_cnt_d = CNT_W'(coll_cnt_q + 1'b1);
            end
        end else if (load_c) begin
            // Nothing to load: drop valid, keep last word/channel/pointer
            out_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
            coll_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            coll_cnt_q  <= coll_cnt_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.collision_cnt = coll_cnt_q;

endmodule

// File: tb/tb_prio_case_arbiter.sv
// Bench for prio_case_arbiter: fixed priority, round-robin and 2-bit saturating counter instances.
module tb_prio_case_arbiter;
    logic clk;
    logic rst;

    prio_case_arbiter_if #(.N(4), .W(8), .CNT_W(8)) if0 ();
    prio_case_arbiter_if #(.N(4), .W(8), .CNT_W(8)) if1 ();
    prio_case_arbiter_if #(.N(4), .W(8), .CNT_W(2)) if2 ();

    prio_case_arbiter #(.N(4), .W(8), .MODE(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
    prio_case_arbiter #(.N(4), .W(8), .MODE(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(if1));
    prio_case_arbiter #(.N(4), .W(8), .MODE(0), .CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic [3:0]  req;
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  ack;
        logic        v;
        logic [7:0]  d;
        logic [1:0]  ch;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] ch;
        logic [7:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [3:0] rq, input logic rdy, input logic [31:0] dat);
        if0.req = (sel == 0) ? rq : 4'b0; if0.out_ready = (sel == 0) ? rdy : 1'b1; if0.data = dat;
        if1.req = (sel == 1) ? rq : 4'b0; if1.out_ready = (sel == 1) ? rdy : 1'b1; if1.data = dat;
        if2.req = (sel == 2) ? rq : 4'b0; if2.out_ready = (sel == 2) ? rdy : 1'b1; if2.data = dat;
    endtask

    task automatic sample(input int sel, output logic [3:0] ack, output exp_t o);
        case (sel)
            0: begin ack = if0.req_ack; o = '{if0.out_valid, if0.out_data, if0.out_ch, if0.collision_cnt}; end
            1: begin ack = if1.req_ack; o = '{if1.out_valid, if1.out_data, if1.out_ch, if1.collision_cnt}; end
            default: begin ack = if2.req_ack; o = '{if2.out_valid, if2.out_data, if2.out_ch, 8'(if2.collision_cnt)}; end
        endcase
    endtask

    // One cycle: drive at negedge, check req_ack, queue expectation, compare after the edge
    task automatic step(input string tag, input vec_t v);
        logic [3:0] ack;
        exp_t       o;
        exp_t       e;
        @(negedge clk);
        drive(v.sel, v.req, v.rdy, v.data);
        #1;
        sample(v.sel, ack, o);
        chk({tag, " ack"}, 32'(ack), 32'(v.ack));
        sb.push_back('{v.v, v.d, v.ch, v.cnt});
        @(posedge clk);
        #1;
        sample(v.sel, ack, o);
        e = sb.pop_front();
        chk({tag, " valid"}, 32'(o.v), 32'(e.v));
        chk({tag, " data"}, 32'(o.d), 32'(e.d));
        chk({tag, " ch"}, 32'(o.ch), 32'(e.ch));
        chk({tag, " cnt"}, 32'(o.cnt), 32'(e.cnt));
    endtask

    task automatic add(input int s, input logic [3:0] rq, input logic rdy, input logic [31:0] dat,
                       input logic [3:0] ack, input logic v, input logic [7:0] d, input logic [1:0] ch,
                       input logic [7:0] cnt);
        vecs.push_back('{s, rq, rdy, dat, ack, v, d, ch, cnt});
    endtask

    localparam logic [31:0] D0 = 32'h3322110F;

    initial begin
        logic [3:0] ack;
        exp_t       o;
        vec_t       v;

        // Fixed priority (u0)
        add(0, 4'b1010, 1, D0,           4'b0010, 1, 8'h11, 2'd1, 8'd1);
        add(0, 4'b1100, 1, D0,           4'b0100, 1, 8'h22, 2'd2, 8'd2);
        add(0, 4'b0000, 1, D0,           4'b0000, 0, 8'h22, 2'd2, 8'd2);
        add(0, 4'b1000, 0, D0,           4'b1000, 1, 8'h33, 2'd3, 8'd2);
        add(0, 4'b0001, 0, D0,           4'b0000, 1, 8'h33, 2'd3, 8'd2);
        add(0, 4'b1111, 1, D0,           4'b0001, 1, 8'h0F, 2'd0, 8'd3);
        add(0, 4'b0010, 1, 32'h33225A0F, 4'b0010, 1, 8'h5A, 2'd1, 8'd3);
        add(0, 4'b0000, 1, 32'h33225A0F, 4'b0000, 0, 8'h5A, 2'd1, 8'd3);
        add(0, 4'b0110, 1, D0,           4'b0010, 1, 8'h11, 2'd1, 8'd4);
        // Saturating 2-bit collision counter (u2)
        for (int i = 0; i < 5; i++)
            add(2, 4'b0011, 1, D0, 4'b0001, 1, 8'h0F, 2'd0, (i < 3) ? 8'(i + 1) : 8'd3);
        add(2, 4'b0000, 1, D0, 4'b0000, 0, 8'h0F, 2'd0, 8'd3);
        // Round-robin (u1): all requesting, then 1001, then backpressure
        for (int i = 0; i < 8; i++)
            add(1, 4'b1111, 1, D0, 4'(1 << (i % 4)), 1, D0[(i % 4) * 8 +: 8], 2'(i % 4), 8'(i + 1));
        add(1, 4'b1001, 1, D0, 4'b0001, 1, 8'h0F, 2'd0, 8'd9);
        add(1, 4'b1001, 1, D0, 4'b1000, 1, 8'h33, 2'd3, 8'd10);
        add(1, 4'b1001, 1, D0, 4'b0001, 1, 8'h0F, 2'd0, 8'd11);
        add(1, 4'b1001, 1, D0, 4'b1000, 1, 8'h33, 2'd3, 8'd12);
        add(1, 4'b0100, 1, 32'h33A5110F, 4'b0100, 1, 8'hA5, 2'd2, 8'd12);
        for (int i = 0; i < 5; i++)
            add(1, 4'b0001, 0, D0, 4'b0000, 1, 8'hA5, 2'd2, 8'd12);
        add(1, 4'b0001, 1, D0, 4'b0001, 1, 8'h0F, 2'd0, 8'd12);
        add(1, 4'b1111, 1, D0, 4'b0010, 1, 8'h11, 2'd1, 8'd13);

        // Reset state, with a request present on u0
        rst = 1'b1;
        drive(0, 4'b1111, 1'b0, D0);
        #2;
        chk("rst ack", 32'(if0.req_ack), 32'h0);
        sample(0, ack, o);
        chk("rst valid0", 32'(o.v), 32'h0);
        chk("rst data0", 32'(o.d), 32'h0);
        chk("rst ch0", 32'(o.ch), 32'h0);
        chk("rst cnt0", 32'(o.cnt), 32'h0);
        chk("rst valid1", 32'(if1.out_valid), 32'h0);
        chk("rst cnt2", 32'(if2.collision_cnt), 32'h0);
        drive(0, 4'b0000, 1'b1, D0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            step($sformatf("vec%0d", i), v);
        end

        // Asynchronous reset mid-cycle while u1 holds a valid word
        #2;
        rst = 1'b1;
        #1;
        chk("arst valid", 32'(if1.out_valid), 32'h0);
        chk("arst data", 32'(if1.out_data), 32'h0);
        chk("arst ch", 32'(if1.out_ch), 32'h0);
        chk("arst cnt", 32'(if1.collision_cnt), 32'h0);
        chk("arst ack", 32'(if1.req_ack), 32'h0);
        drive(1, 4'b0000, 1'b1, D0);
        @(negedge clk);
        rst = 1'b0;
        // Round-robin restarts from channel 0
        step("post0", '{1, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h0F, 2'd0, 8'd1});
        step("post1", '{1, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h11, 2'd1, 8'd2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
